// File: rtl/master.sv
// Initiator side of a four-phase req/ack handshake moving one nibble over a shared
// tri-state bus; ack is asynchronous and is synchronised before any FSM decision.
module master #(
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [3:0] wr_data,
  input  logic       ack,
  output logic       req,
  inout  wire  [3:0] data_bus,
  output logic [3:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    REQ_HI = 3'd2,
    REQ_LO = 3'd3,
    DONE   = 3'd4,
    ABORT  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             ack_m, ack_s;
  logic             rw_q;
  logic [3:0]       wd_q;
  logic             drive;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= ack;
      ack_s <= ack_m;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = SETUP;
      SETUP:  if (cnt == SETUP_LAST) state_nxt = REQ_HI;
      REQ_HI: begin
        if (ack_s)               state_nxt = REQ_LO;
        else if (cnt == TO_LAST) state_nxt = ABORT;
      end
      REQ_LO: begin
        if (!ack_s)              state_nxt = DONE;
        else if (cnt == TO_LAST) state_nxt = ABORT;
      end
      DONE:    state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One counter serves both setup timing and per-phase timeout; it restarts on
  // every state change so each phase gets its own full budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rw_q    <= 1'b0;
      wd_q    <= 4'h0;
      rd_data <= 4'h0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == IDLE) cnt <= '0;
      else                                     cnt <= cnt + 1'b1;
      if (state == IDLE && start) begin
        rw_q <= rw;
        wd_q <= wr_data;
      end
      if (state == REQ_HI && ack_s && !rw_q) rd_data <= data_bus;
    end
  end

  // Outputs decode straight from the state register so reset releases req and
  // the bus immediately, without waiting for a clock edge.
  assign drive       = rw_q && (state == SETUP || state == REQ_HI || state == REQ_LO);
  assign data_bus    = drive ? wd_q : 4'bz;
  assign req         = (state == REQ_HI);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign timeout_err = (state == ABORT);

endmodule

// File: doc/master.md
Name: master

Overview:
- Initiator end of the four-phase asynchronous req/ack handshake over the shared 4-bit bidirectional data bus.
- Accepts a single-cycle start command (read or write) from local logic.
- Launches req, waits for the responder's ack (synchronised internally), moves one nibble, completes the return-to-zero phase, and reports done or timeout.
- Sits opposite the responder on the same bus.

Parameters:
- SETUP_CYC, 2, cycles data is driven on data_bus (write) before req rises; minimum 1.
- TIMEOUT_CYC, 64, max cycles waiting in any single handshake phase before abort; minimum 4.
- CNT_W, 8, width of the internal timeout/setup counter; must hold TIMEOUT_CYC.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- rw  input  1  1 = master write (master drives bus), 0 = master read (responder drives bus); sampled with start.
- wr_data  input  4  write nibble; sampled with start.
- ack  input  1  responder acknowledge; asynchronous to clk.
- req  output  1  handshake request to responder.
- data_bus  inout  4  shared bus; master drives only during a write transaction, else high-Z.
- rd_data  output  4  last nibble captured on a read.
- busy  output  1  high from the cycle after start is accepted until IDLE is re-entered.
- done  output  1  one-cycle pulse on successful completion.
- timeout_err  output  1  one-cycle pulse on abort.

Behaviour:
- Reset (async, immediate) values:
  - state = IDLE; req = 0; data_bus = Z; rd_data = 0; busy = 0; done = 0; timeout_err = 0.
  - Synchroniser flops = 0; counter = 0.
- ack passes through a 2-flop synchroniser (ack_s); all FSM decisions use ack_s only. ack therefore affects the FSM 2 clocks after it changes.
- Latched command: rw_q and wd_q capture rw and wr_data on the edge where start=1 in IDLE. Later changes to rw, wr_data or start are ignored until IDLE.
- FSM states and transitions:
  - IDLE: start=1 -> SETUP, counter cleared, busy=1 next cycle.
  - SETUP: req=0; bus driven with wd_q if rw_q=1. Stays exactly SETUP_CYC cycles, then -> REQ_HI.
  - REQ_HI: req=1; bus driven with wd_q if rw_q=1.
    - ack_s=1 -> REQ_LO. On a read, rd_data <= data_bus on that same edge.
    - Counter reaching TIMEOUT_CYC-1 with ack_s=0 -> ABORT.
  - REQ_LO: req=0. Write data is held on the bus throughout this state (hold time).
    - ack_s=0 -> DONE.
    - Timeout as above -> ABORT.
  - DONE: done=1 for this cycle; bus Z; -> IDLE. busy=0 from the IDLE cycle on.
  - ABORT: req=0; bus Z; timeout_err=1 for this cycle; rd_data unchanged; -> IDLE.
- Counter: clears on every state change and increments otherwise. It is shared by setup timing and timeout.
- Bus drive: data_bus = wd_q when rw_q=1 and state is SETUP, REQ_HI or REQ_LO; otherwise Z in every state. On a read the master never drives.
- Boundary conditions:
  - start while busy: ignored, no queuing.
  - start in the DONE/ABORT cycle: ignored.
  - ack already high when REQ_HI is entered: handshake proceeds immediately after synchroniser latency.
  - ack glitch shorter than 1 clock: may be missed. Only a stable level is required to be honoured.
  - rst mid-transaction: req drops and the bus releases asynchronously; no done or timeout_err pulse.
  - done and timeout_err are never high together.

Test Plan:
- Write 4'hA, SETUP_CYC=2, responder acks 3 cycles after req and drops ack 2 cycles after req falls:
  - data_bus=A for the whole of SETUP..REQ_LO, req rises 2 cycles after busy.
  - done pulses once, then bus goes Z.
- Read, responder drives 4'h9 while ack=1 -> rd_data=9 after completion; data_bus never driven by the master; done pulses.
- No ack, TIMEOUT_CYC=64 -> req high for 64 cycles in REQ_HI, then ABORT.
  - timeout_err pulses once; req=0; busy falls; rd_data unchanged.
- ack held high after req falls beyond TIMEOUT_CYC -> ABORT from REQ_LO with timeout_err, no done.
- start re-pulsed with rw/wr_data=5 mid-transaction of a write of 3 -> bus stays 3; second command ignored; exactly one done.
- rst asserted during REQ_HI of a write -> req=0 and data_bus=Z with no clock edge; after release, a new write of 4'h6 completes normally.
